// File: rtl/uart_tx_rx_if.sv
// uart_tx_rx_if: serial pins, tick, tx request and rx slot bundle.
// master drives tick/start/din/rx/sel; slave returns tx, dout, done ticks.
interface uart_tx_rx_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            tx;
    logic            tx_done_tick;
    logic            rx;
    logic            sel;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;

    modport master (
        output s_tick, tx_start, din, rx, sel,
        input  tx, tx_done_tick, dout, rx_done_tick
    );

    modport slave (
        input  s_tick, tx_start, din, rx, sel,
        output tx, tx_done_tick, dout, rx_done_tick
    );
endinterface

// File: rtl/uart_tx_rx.sv
// uart_tx_rx: 16x-oversampled full-duplex UART, two selectable rx slots.
// Ports: clk, reset (async active-low), bus (uart_tx_rx_if.slave).
module uart_tx_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_rx_if.slave  bus
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] NLAST = NW'(DBIT - 1);
    localparam logic [3:0]    SLAST = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } st_t;

    st_t             ts_q, ts_d;
    logic [3:0]      tt_q, tt_d;
    logic [NW-1:0]   tn_q, tn_d;
    logic [DBIT-1:0] tb_q, tb_d;
    logic            tx_q, tx_d;
    logic            tdn_q, tdn_d;

    st_t             rs_q, rs_d;
    logic [3:0]      rt_q, rt_d;
    logic [NW-1:0]   rn_q, rn_d;
    logic [DBIT-1:0] rb_q, rb_d;
    logic            rdn_q, rdn_d;
    logic [DBIT-1:0] sl0_q, sl0_d;
    logic [DBIT-1:0] sl1_q, sl1_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q  <= IDLE;
            tt_q  <= '0;
            tn_q  <= '0;
            tb_q  <= '0;
            tx_q  <= 1'b1;
            tdn_q <= 1'b0;
            rs_q  <= IDLE;
            rt_q  <= '0;
            rn_q  <= '0;
            rb_q  <= '0;
            rdn_q <= 1'b0;
            sl0_q <= '0;
            sl1_q <= '0;
        end else begin
            ts_q  <= ts_d;
            tt_q  <= tt_d;
            tn_q  <= tn_d;
            tb_q  <= tb_d;
            tx_q  <= tx_d;
            tdn_q <= tdn_d;
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            rn_q  <= rn_d;
            rb_q  <= rb_d;
            rdn_q <= rdn_d;
            sl0_q <= sl0_d;
            sl1_q <= sl1_d;
        end
    end

    always_comb begin
        ts_d  = ts_q;
        tt_d  = tt_q;
        tn_d  = tn_q;
        tb_d  = tb_q;
        tdn_d = 1'b0;
        unique case (ts_q)
            IDLE: begin
                if (bus.tx_start) begin
                    ts_d = START;
                    tt_d = '0;
                    tn_d = '0;
                    tb_d = bus.din;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (tt_q == 4'd15) begin
                        tt_d = '0;
                        ts_d = DATA;
                    end else begin
                        tt_d = tt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (tt_q == 4'd15) begin
                        tt_d = '0;
                        tb_d = tb_q >> 1;
                        if (tn_q == NLAST) ts_d = STOP;
                        else tn_d = tn_q + 1'b1;
                    end else begin
                        tt_d = tt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (tt_q == SLAST) begin
                        tdn_d = 1'b1;
                        ts_d  = IDLE;
                    end else begin
                        tt_d = tt_q + 4'd1;
                    end
                end
            end
            default: ts_d = IDLE;
        endcase
        // Level follows the next state so the start bit
        // appears the cycle right after tx_start.
        tx_d = 1'b1;
        if (ts_d == START) tx_d = 1'b0;
        else if (ts_d == DATA) tx_d = tb_d[0];
    end

    always_comb begin
        rs_d  = rs_q;
        rt_d  = rt_q;
        rn_d  = rn_q;
        rb_d  = rb_q;
        rdn_d = 1'b0;
        sl0_d = sl0_q;
        sl1_d = sl1_q;
        unique case (rs_q)
            IDLE: begin
                if (!bus.rx) begin
                    rt_d = '0;
                    rs_d = START;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (rt_q == 4'd7) begin
                        // Mid start bit: high here means a glitch.
                        if (!bus.rx) begin
                            rt_d = '0;
                            rn_d = '0;
                            rs_d = DATA;
                        end else begin
                            rs_d = IDLE;
                        end
                    end else begin
                        rt_d = rt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (rt_q == 4'd15) begin
                        rt_d = '0;
                        rb_d = {bus.rx, rb_q[DBIT-1:1]};
                        if (rn_q == NLAST) rs_d = STOP;
                        else rn_d = rn_q + 1'b1;
                    end else begin
                        rt_d = rt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (rt_q == SLAST) begin
                        if (bus.sel) sl1_d = rb_q;
                        else sl0_d = rb_q;
                        rdn_d = 1'b1;
                        rs_d  = IDLE;
                    end else begin
                        rt_d = rt_q + 4'd1;
                    end
                end
            end
            default: rs_d = IDLE;
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.tx_done_tick = tdn_q;
    assign bus.rx_done_tick = rdn_q;
    assign bus.dout         = bus.sel ? sl1_q : sl0_q;
endmodule

// File: tb/tb_uart_tx_rx.sv
// tb_uart_tx_rx: loopback scoreboard bench for uart_tx_rx.
// Stimulus pushes expected bytes; a negedge monitor pops and compares.
module tb_uart_tx_rx;
    logic clk;
    logic reset;
    logic loop;
    logic rx_drv;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rx_cnt = 0;
    int   tx_cnt = 0;
    int   tcnt = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    uart_tx_rx_if #(.DBIT(8)) u ();

    uart_tx_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u)
    );

    assign u.rx = loop ? u.tx : rx_drv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // s_tick every 4 clocks: one bit = 64 clocks.
    initial begin
        u.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt = (tcnt + 1) % 4;
            u.s_tick = (tcnt == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus a tx line sniffer that samples
    // each bit 32 clocks after its nominal start.
    initial begin
        logic       sn_act;
        int         sn_cnt;
        logic [7:0] sn_byte;
        logic [7:0] sn_last;
        logic [7:0] e;
        sn_act  = 1'b0;
        sn_cnt  = 0;
        sn_byte = '0;
        sn_last = 'x;
        forever begin
            @(negedge clk);
            if (!reset) begin
                sn_act  = 1'b0;
                sn_last = 'x;
            end else begin
                if (u.rx_done_tick) begin
                    rx_cnt++;
                    if (rx_q.size() == 0) begin
                        chk("rx_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = rx_q.pop_front();
                        chk("rx_byte", {24'd0, u.dout}, {24'd0, e});
                    end
                end
                if (u.tx_done_tick) begin
                    tx_cnt++;
                    if (tx_q.size() == 0) begin
                        chk("tx_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = tx_q.pop_front();
                        chk("tx_line_byte", {24'd0, sn_last},
                            {24'd0, e});
                    end
                    sn_last = 'x;
                end
                if (!sn_act) begin
                    if (u.tx == 1'b0) begin
                        sn_act = 1'b1;
                        sn_cnt = 0;
                    end
                end else begin
                    sn_cnt++;
                    if (sn_cnt % 64 == 32) begin
                        if (sn_cnt / 64 == 0) begin
                            chk("tx_start_bit", {31'd0, u.tx}, 32'd0);
                        end else if (sn_cnt / 64 <= 8) begin
                            sn_byte[sn_cnt/64-1] = u.tx;
                        end else begin
                            chk("tx_stop_bit", {31'd0, u.tx}, 32'd1);
                            sn_last = sn_byte;
                            sn_act  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic exp_rx);
        @(negedge clk);
        u.din      = b;
        u.tx_start = 1'b1;
        tx_q.push_back(b);
        if (exp_rx) rx_q.push_back(b);
        @(negedge clk);
        u.tx_start = 1'b0;
    endtask

    task automatic wait_done(input int rxt, input int txt,
                             input string nm);
        int k;
        k = 0;
        while ((rx_cnt < rxt || tx_cnt < txt) && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'd0, (rx_cnt >= rxt && tx_cnt >= txt)}, 32'd1);
    endtask

    initial begin
        int r0;
        int t0;
        int lows;
        reset      = 1'b0;
        loop       = 1'b1;
        rx_drv     = 1'b1;
        u.tx_start = 1'b0;
        u.din      = '0;
        u.sel      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", {31'd0, u.tx}, 32'd1);
        chk("rst_txdone", {31'd0, u.tx_done_tick}, 32'd0);
        chk("rst_rxdone", {31'd0, u.rx_done_tick}, 32'd0);
        chk("rst_slot0", {24'd0, u.dout}, 32'h00);
        u.sel = 1'b1;
        #1;
        chk("rst_slot1", {24'd0, u.dout}, 32'h00);
        u.sel = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        send(8'hAA, 1'b1);
        wait_done(1, 1, "aa_timeout");
        #1;
        chk("aa_dout", {24'd0, u.dout}, 32'hAA);

        u.sel = 1'b1;
        send(8'h0F, 1'b1);
        wait_done(2, 2, "0f_timeout");
        #1;
        chk("0f_dout", {24'd0, u.dout}, 32'h0F);
        u.sel = 1'b0;
        #1;
        chk("slot0_kept", {24'd0, u.dout}, 32'hAA);
        u.sel = 1'b1;
        #1;
        chk("slot1_kept", {24'd0, u.dout}, 32'h0F);
        u.sel = 1'b0;

        r0 = rx_cnt;
        t0 = tx_cnt;
        send(8'h3C, 1'b1);
        repeat (200) @(negedge clk);
        u.din      = 8'h55;
        u.tx_start = 1'b1;
        @(negedge clk);
        u.tx_start = 1'b0;
        wait_done(r0 + 1, t0 + 1, "3c_timeout");
        repeat (800) @(negedge clk);
        chk("3c_tx_dones", tx_cnt - t0, 32'd1);
        chk("3c_rx_dones", rx_cnt - r0, 32'd1);
        chk("3c_dout", {24'd0, u.dout}, 32'h3C);

        send(8'h81, 1'b1);
        repeat (300) @(negedge clk);
        reset = 1'b0;
        rx_q.delete();
        tx_q.delete();
        #1;
        chk("mid_rst_tx", {31'd0, u.tx}, 32'd1);
        chk("mid_rst_txdone", {31'd0, u.tx_done_tick}, 32'd0);
        chk("mid_rst_rxdone", {31'd0, u.rx_done_tick}, 32'd0);
        chk("mid_rst_slot0", {24'd0, u.dout}, 32'h00);
        u.sel = 1'b1;
        #1;
        chk("mid_rst_slot1", {24'd0, u.dout}, 32'h00);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        r0 = rx_cnt;
        t0 = tx_cnt;
        repeat (1300) @(negedge clk);
        chk("post_rst_txd", tx_cnt - t0, 32'd0);
        chk("post_rst_rxd", rx_cnt - r0, 32'd0);
        send(8'hC3, 1'b1);
        wait_done(r0 + 1, t0 + 1, "c3_timeout");
        #1;
        chk("c3_dout", {24'd0, u.dout}, 32'hC3);
        u.sel = 1'b0;
        #1;
        chk("c3_slot0_clr", {24'd0, u.dout}, 32'h00);

        repeat (100) @(negedge clk);
        r0     = rx_cnt;
        loop   = 1'b0;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (800) @(negedge clk);
        chk("glitch_rxd", rx_cnt - r0, 32'd0);
        loop = 1'b1;
        send(8'h5A, 1'b1);
        wait_done(r0 + 1, tx_cnt + 1, "5a_timeout");
        #1;
        chk("5a_dout", {24'd0, u.dout}, 32'h5A);

        repeat (100) @(negedge clk);
        r0   = rx_cnt;
        t0   = tx_cnt;
        lows = 0;
        repeat (1280) begin
            @(negedge clk);
            if (u.tx !== 1'b1) lows++;
        end
        chk("idle_tx_low", lows, 32'd0);
        chk("idle_txd", tx_cnt - t0, 32'd0);
        chk("idle_rxd", rx_cnt - r0, 32'd0);
        chk("rx_q_empty", rx_q.size(), 32'd0);
        chk("tx_q_empty", tx_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
